// File: rtl/regfile_pkg.sv
// Shared definitions for the architectural register file: geometry of the
// register array and the index/word types used on every port.
package regfile_pkg;

  localparam int DATA_W   = 64;  // register width in bits
  localparam int NUM_REGS = 32;  // architectural registers, including X31
  localparam int ADDR_W   = 5;   // register index width
  localparam int ZERO_REG = 31;  // hard-wired zero register, has no storage

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_word_t;

  // Packed view of every architectural register, used by the read muxes.
  typedef logic [NUM_REGS-1:0][DATA_W-1:0] reg_bank_t;

endpackage : regfile_pkg

// File: rtl/regfile_decoder.sv
// Write-address decoder: turns the destination index into a one-hot vector
// of per-register write enables, gated by the global write enable. The enable
// for the zero register is always low, so writes to X31 are dropped here.
module regfile_decoder
  import regfile_pkg::*;
(
  input  logic                we_i,
  input  reg_idx_t            idx_i,
  output logic [NUM_REGS-1:0] we_o
);

  // One-hot decode of the write index, with the zero register masked off.
  always_comb begin
    // NOTE: every bit gets a value before any condition is evaluated, so no
    // path leaves we_o unassigned and no latch is inferred.
    we_o = '0;
    if (we_i) begin
      // NOTE: blocking assignments in combinational logic; later statements
      // in this block intentionally override earlier ones.
      we_o[idx_i] = 1'b1;
    end
    we_o[ZERO_REG] = 1'b0;
  end

endmodule : regfile_decoder

// File: rtl/regfile_mux.sv
// 32:1 read multiplexer over the packed register bank. Purely combinational;
// the caller supplies a constant zero in the X31 slot.
module regfile_mux
  import regfile_pkg::*;
(
  input  reg_bank_t words_i,
  input  reg_idx_t  sel_i,
  output reg_word_t data_o
);

  // The 5-bit index covers all 32 slots, so no out-of-range case exists.
  assign data_o = words_i[sel_i];

endmodule : regfile_mux

// File: rtl/reg_file.sv
// 64-bit, 32-entry architectural register file: two combinational read ports
// and one clocked write port. X31 is hard-wired to zero and has no storage.
// No forwarding: a read of the register being written shows the old value
// until the committing edge.
module reg_file
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      RegWrite,
  input  reg_idx_t  WriteRegister,
  input  reg_word_t WriteData,
  input  reg_idx_t  ReadRegister1,
  input  reg_idx_t  ReadRegister2,
  output reg_word_t ReadData1,
  output reg_word_t ReadData2
);

  // The geometry is fixed by the ISA; the parameters exist so that an
  // integration that expects a different shape fails at elaboration.
  if (DATA_W   != regfile_pkg::DATA_W   ||
      NUM_REGS != regfile_pkg::NUM_REGS ||
      ADDR_W   != regfile_pkg::ADDR_W   ||
      ZERO_REG != regfile_pkg::ZERO_REG) begin : g_bad_params
    $error("reg_file: parameters do not match the fixed ISA geometry");
  end

  logic [NUM_REGS-1:0] wr_en;
  logic                zero_we_unused;
  reg_bank_t           bank;

  regfile_decoder u_decoder (
    .we_i  (RegWrite),
    .idx_i (WriteRegister),
    .we_o  (wr_en)
  );

  // The decoder ties this enable low; it has no register to drive.
  assign zero_we_unused = wr_en[ZERO_REG];

  // X31 reads as a constant zero.
  assign bank[ZERO_REG] = '0;

  for (genvar i = 0; i < ZERO_REG; i++) begin : g_reg
    reg_word_t reg_q;
    reg_word_t reg_d;

    // Next state: load the full 64-bit word when this register is selected.
    always_comb begin
      reg_d = wr_en[i] ? WriteData : reg_q;
    end

    // Register storage; reset clears it asynchronously and wins over writes.
    always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: this storage is reset on purpose: every architectural register
      // must read zero out of reset, so a reset-less RAM macro cannot be used.
      if (!rst_n) begin
        reg_q <= '0;
      end else begin
        reg_q <= reg_d;
      end
    end

    assign bank[i] = reg_q;
  end

  regfile_mux u_rd_mux1 (
    .words_i (bank),
    .sel_i   (ReadRegister1),
    .data_o  (ReadData1)
  );

  regfile_mux u_rd_mux2 (
    .words_i (bank),
    .sel_i   (ReadRegister2),
    .data_o  (ReadData2)
  );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed scenarios plus randomized traffic, checked
// against an array model of the 31 writable registers.
module tb_reg_file;
  import regfile_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      RegWrite;
  reg_idx_t  WriteRegister;
  reg_word_t WriteData;
  reg_idx_t  ReadRegister1;
  reg_idx_t  ReadRegister2;
  reg_word_t ReadData1;
  reg_word_t ReadData2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam reg_word_t PATTERN = 64'h0000010204080001;

  // Model of the writable registers X0..X30.
  reg_word_t model [31];

  reg_file dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (time %0t, limit 2000000)", $time);
    $fatal(1);
  end

  function automatic reg_word_t model_read(input reg_idx_t idx);
    if (idx == 5'd31) return '0;
    return model[idx];
  endfunction

  function automatic void model_write(input logic we, input reg_idx_t idx,
                                      input reg_word_t data);
    if (we && idx != 5'd31) model[idx] = data;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 31; i++) model[i] = '0;
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    RegWrite = 1'b0;
    WriteRegister = '0;
    WriteData = '0;
    model_clear();
    for (int i = 0; i < 32; i += 3) begin
      ReadRegister1 = reg_idx_t'(i);
      ReadRegister2 = reg_idx_t'(31 - i);
      #1;
      total_cnt++;
      if (ReadData1 !== 64'd0) $display("FAIL reset_rd1 idx=%0d got=%h exp=0", i, ReadData1);
      else pass_cnt++;
      total_cnt++;
      if (ReadData2 !== 64'd0) $display("FAIL reset_rd2 idx=%0d got=%h exp=0", 31 - i, ReadData2);
      else pass_cnt++;
    end
    // Release away from the rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_zero_reg();
    RegWrite = 1'b1;
    WriteRegister = 5'd31;
    WriteData = 64'h00000000000000A0;
    model_write(RegWrite, WriteRegister, WriteData);
    step();
    RegWrite = 1'b0;
    ReadRegister1 = 5'd31;
    ReadRegister2 = 5'd31;
    #1;
    total_cnt++;
    if (ReadData1 !== 64'd0) $display("FAIL zero_reg_rd1 got=%h exp=0", ReadData1);
    else pass_cnt++;
    total_cnt++;
    if (ReadData2 !== 64'd0) $display("FAIL zero_reg_rd2 got=%h exp=0", ReadData2);
    else pass_cnt++;
    // The discarded write must not have landed anywhere else.
    for (int i = 0; i < 31; i++) begin
      ReadRegister1 = reg_idx_t'(i);
      #1;
      total_cnt++;
      if (ReadData1 !== model_read(reg_idx_t'(i)))
        $display("FAIL zero_reg_side_effect X%0d got=%h exp=%h", i, ReadData1, model_read(reg_idx_t'(i)));
      else pass_cnt++;
    end
  endtask

  task automatic test_pattern_fill();
    for (int i = 0; i < 31; i++) begin
      WriteRegister = reg_idx_t'(i);
      WriteData = PATTERN * 64'(i);
      ReadRegister1 = reg_idx_t'(i);
      RegWrite = 1'b0;
      step();
      total_cnt++;
      if (ReadData1 !== model_read(reg_idx_t'(i)))
        $display("FAIL fill_disabled X%0d got=%h exp=%h", i, ReadData1, model_read(reg_idx_t'(i)));
      else pass_cnt++;
      RegWrite = 1'b1;
      model_write(1'b1, reg_idx_t'(i), PATTERN * 64'(i));
      step();
      total_cnt++;
      if (ReadData1 !== model_read(reg_idx_t'(i)))
        $display("FAIL fill_enabled X%0d got=%h exp=%h", i, ReadData1, model_read(reg_idx_t'(i)));
      else pass_cnt++;
    end
    RegWrite = 1'b0;
    ReadRegister2 = 5'd30;
    #1;
    total_cnt++;
    if (ReadData2 !== 64'h00001E3C78F0001E)
      $display("FAIL fill_x30 got=%h exp=00001e3c78f0001e", ReadData2);
    else pass_cnt++;
  endtask

  task automatic test_retention();
    RegWrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      WriteData = 64'(i) * 64'h101;
      WriteRegister = reg_idx_t'(i);
      ReadRegister2 = reg_idx_t'(i);
      ReadRegister1 = reg_idx_t'(i - 1);
      step();
      total_cnt++;
      if (ReadData2 !== model_read(reg_idx_t'(i)))
        $display("FAIL retention_rd2 idx=%0d got=%h exp=%h", i, ReadData2, model_read(reg_idx_t'(i)));
      else pass_cnt++;
      total_cnt++;
      if (ReadData1 !== model_read(reg_idx_t'(i - 1)))
        $display("FAIL retention_rd1 idx=%0d got=%h exp=%h", (i + 31) % 32, ReadData1, model_read(reg_idx_t'(i - 1)));
      else pass_cnt++;
    end
  endtask

  task automatic test_same_cycle();
    ReadRegister1 = 5'd5;
    WriteRegister = 5'd5;
    WriteData = 64'h11;
    RegWrite = 1'b1;
    model_write(1'b1, 5'd5, 64'h11);
    step();
    WriteData = 64'h22;
    #1;
    total_cnt++;
    if (ReadData1 !== 64'h11) $display("FAIL same_cycle_before got=%h exp=11", ReadData1);
    else pass_cnt++;
    model_write(1'b1, 5'd5, 64'h22);
    step();
    total_cnt++;
    if (ReadData1 !== 64'h22) $display("FAIL same_cycle_after got=%h exp=22", ReadData1);
    else pass_cnt++;
    RegWrite = 1'b0;
  endtask

  task automatic test_async_reset();
    // Registers are filled from the earlier scenarios; pull reset mid-cycle
    // with a write pending so the next edge also sees reset win.
    RegWrite = 1'b1;
    WriteRegister = 5'd9;
    WriteData = 64'hFFFF_FFFF_FFFF_FFFF;
    ReadRegister1 = 5'd30;
    ReadRegister2 = 5'd5;
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    total_cnt++;
    if (ReadData1 !== 64'd0) $display("FAIL async_reset_immediate_rd1 got=%h exp=0", ReadData1);
    else pass_cnt++;
    total_cnt++;
    if (ReadData2 !== 64'd0) $display("FAIL async_reset_immediate_rd2 got=%h exp=0", ReadData2);
    else pass_cnt++;
    step();
    ReadRegister1 = 5'd9;
    #1;
    total_cnt++;
    if (ReadData1 !== 64'd0) $display("FAIL async_reset_overrides_write got=%h exp=0", ReadData1);
    else pass_cnt++;
    RegWrite = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    RegWrite = 1'b1;
    WriteRegister = 5'd3;
    WriteData = 64'hDEADBEEF;
    model_write(1'b1, 5'd3, 64'hDEADBEEF);
    step();
    RegWrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = reg_idx_t'(i);
      ReadRegister2 = reg_idx_t'(31 - i);
      #1;
      total_cnt++;
      if (ReadData1 !== model_read(reg_idx_t'(i)))
        $display("FAIL post_reset_rd1 X%0d got=%h exp=%h", i, ReadData1, model_read(reg_idx_t'(i)));
      else pass_cnt++;
      total_cnt++;
      if (ReadData2 !== model_read(reg_idx_t'(31 - i)))
        $display("FAIL post_reset_rd2 X%0d got=%h exp=%h", 31 - i, ReadData2, model_read(reg_idx_t'(31 - i)));
      else pass_cnt++;
    end
  endtask

  task automatic test_dual_port();
    // Give X0, X7 and X30 distinct contents first.
    RegWrite = 1'b1;
    for (int k = 0; k < 3; k++) begin
      reg_idx_t  idx;
      reg_word_t val;
      idx = (k == 0) ? 5'd0 : (k == 1) ? 5'd7 : 5'd30;
      val = {$urandom, $urandom};
      WriteRegister = idx;
      WriteData = val;
      model_write(1'b1, idx, val);
      step();
    end
    RegWrite = 1'b0;
    ReadRegister1 = 5'd7;
    ReadRegister2 = 5'd7;
    #1;
    total_cnt++;
    if (ReadData1 !== model_read(5'd7)) $display("FAIL dual_same_rd1 got=%h exp=%h", ReadData1, model_read(5'd7));
    else pass_cnt++;
    total_cnt++;
    if (ReadData2 !== model_read(5'd7)) $display("FAIL dual_same_rd2 got=%h exp=%h", ReadData2, model_read(5'd7));
    else pass_cnt++;
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd30;
    #1;
    total_cnt++;
    if (ReadData1 !== model_read(5'd0)) $display("FAIL dual_split_rd1 got=%h exp=%h", ReadData1, model_read(5'd0));
    else pass_cnt++;
    total_cnt++;
    if (ReadData2 !== model_read(5'd30)) $display("FAIL dual_split_rd2 got=%h exp=%h", ReadData2, model_read(5'd30));
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      RegWrite = logic'($urandom_range(0, 1));
      WriteRegister = reg_idx_t'($urandom_range(0, 31));
      WriteData = {$urandom, $urandom};
      ReadRegister1 = reg_idx_t'($urandom_range(0, 31));
      ReadRegister2 = (n % 4 == 0) ? WriteRegister : reg_idx_t'($urandom_range(0, 31));
      #1;
      // Before the edge: old contents, no write-through.
      total_cnt++;
      if (ReadData1 !== model_read(ReadRegister1))
        $display("FAIL random_rd1 n=%0d idx=%0d got=%h exp=%h", n, ReadRegister1, ReadData1, model_read(ReadRegister1));
      else pass_cnt++;
      total_cnt++;
      if (ReadData2 !== model_read(ReadRegister2))
        $display("FAIL random_rd2 n=%0d idx=%0d got=%h exp=%h", n, ReadRegister2, ReadData2, model_read(ReadRegister2));
      else pass_cnt++;
      model_write(RegWrite, WriteRegister, WriteData);
      step();
    end
    RegWrite = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_pattern_fill();
    test_retention();
    test_same_cycle();
    test_dual_port();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_reg_file
